// File: rtl/bg_rom_arbiter_pkg.sv
// Shared types for the background ROM arbiter: default widths, the port-owner
// enum and the tag that travels alongside each ROM read.
package bg_arb_pkg;

  localparam int ADDR_W_DEF = 17;  // 320x240 background
  localparam int DATA_W_DEF = 4;   // palette index

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  // vld  : a read was issued in this slot
  // owner: who receives rom_q
  // miss : a display request was displaced by this (CPU) read
  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   miss;
  } tag_t;

endpackage

// File: rtl/bg_rom_arbiter_if.sv
// Bus bundle between the display fetcher, the game-logic CPU, the ROM and the
// arbiter. The arbiter uses the slave modport; clients/ROM use master.
interface bg_rom_arbiter_if
  import bg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_miss;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_addr, rom_q,
    output disp_valid, disp_data, disp_miss, cpu_gnt, cpu_valid, cpu_data,
           rom_en, rom_addr
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_addr, rom_q,
    input  disp_valid, disp_data, disp_miss, cpu_gnt, cpu_valid, cpu_data,
           rom_en, rom_addr
  );
endinterface

// File: rtl/bg_rom_arbiter_tag_pipe.sv
// Tag delay line: ROM_LAT register stages so the tag leaving the pipe lines up
// with the rom_q word produced for the same issue.
module bg_arb_tag_pipe
  import bg_arb_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_tag_p [ROM_LAT];

  // Shift the tag one stage per cycle; reset drops every read in flight.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) r_tag_p[i] <= '0;
    end else begin
      r_tag_p[0] <= i_tag;
      for (int i = 1; i < ROM_LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
    end
  end

  assign o_tag = r_tag_p[ROM_LAT-1];

endmodule

// File: rtl/bg_rom_arbiter.sv
// Background ROM arbiter: shares one single-port ROM between the VGA display
// fetcher (priority) and game-logic CPU reads, one read issued per cycle.
// Optional feature macro BG_ARB_STARVE_EN: after STARVE_MAX consecutive denied
// CPU cycles the CPU is forced onto the port and the displaced display read
// comes back flagged with disp_miss and the previous disp_data.
module bg_rom_arbiter
  import bg_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  bg_rom_arbiter_if.slave   bus
);

  if (ROM_LAT < 1 || ROM_LAT > 4 || STARVE_MAX < 1) begin : g_param_err
    $error("bg_rom_arbiter: ROM_LAT must be 1..4 and STARVE_MAX >= 1");
  end

  owner_e            w_owner;
  logic              w_force;
  logic [ADDR_W-1:0] w_rom_addr;
  tag_t              w_tag_in;
  tag_t              w_tag_out;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_cpu_valid;
  logic [DATA_W-1:0] r_cpu_data;

`ifdef BG_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_disp_miss;

  assign w_force = bus.cpu_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // Count consecutive denied CPU cycles, saturating; any grant or idle clears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.cpu_req || bus.cpu_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign bus.disp_miss = r_disp_miss;
`else
  assign w_force       = 1'b0;
  assign bus.disp_miss = 1'b0;
`endif

  // Pick the port owner for this cycle; nobody owns it while in reset.
  always_comb begin
    w_owner = OWN_NONE;
    if (!reset_n)                       w_owner = OWN_NONE;
    else if (bus.disp_req && !w_force)  w_owner = OWN_DISP;
    else if (bus.cpu_req)               w_owner = OWN_CPU;
  end

  assign w_rom_addr   = (w_owner == OWN_CPU) ? bus.cpu_addr : bus.disp_addr;
  assign bus.rom_addr = w_rom_addr;
  assign bus.rom_en   = (w_owner != OWN_NONE);
  assign bus.cpu_gnt  = (w_owner == OWN_CPU);

  // Build the tag that follows this cycle's read through the ROM.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.vld   = (w_owner != OWN_NONE);
    w_tag_in.owner = w_owner;
`ifdef BG_ARB_STARVE_EN
    w_tag_in.miss  = (w_owner == OWN_CPU) && bus.disp_req;
`endif
  end

  bg_arb_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  // Capture rom_q for the tagged owner; data holds between updates.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_cpu_valid  <= 1'b0;
      r_cpu_data   <= '0;
`ifdef BG_ARB_STARVE_EN
      r_disp_miss  <= 1'b0;
`endif
    end else begin
      r_disp_valid <= 1'b0;
      r_cpu_valid  <= 1'b0;
`ifdef BG_ARB_STARVE_EN
      r_disp_miss  <= 1'b0;
      // Displaced display read: report it on time but keep the old pixel.
      if (w_tag_out.vld && w_tag_out.miss) begin
        r_disp_valid <= 1'b1;
        r_disp_miss  <= 1'b1;
      end
`endif
      if (w_tag_out.vld && w_tag_out.owner == OWN_DISP) begin
        r_disp_valid <= 1'b1;
        r_disp_data  <= bus.rom_q;
      end
      if (w_tag_out.vld && w_tag_out.owner == OWN_CPU) begin
        r_cpu_valid <= 1'b1;
        r_cpu_data  <= bus.rom_q;
      end
    end
  end

  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_data  = r_disp_data;
  assign bus.cpu_valid  = r_cpu_valid;
  assign bus.cpu_data   = r_cpu_data;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed bench for bg_rom_arbiter: dut1 uses ROM_LAT=1, dut3 uses ROM_LAT=3.
// Both ROM models return addr[3:0] after ROM_LAT cycles.
module tb_bg_rom_arbiter;
  import bg_arb_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 vga_clk = ~vga_clk;

  bg_rom_arbiter_if #(.ADDR_W(17), .DATA_W(4)) bus1 ();
  bg_rom_arbiter_if #(.ADDR_W(17), .DATA_W(4)) bus3 ();

  bg_rom_arbiter #(.ADDR_W(17), .DATA_W(4), .ROM_LAT(1), .STARVE_MAX(8)) dut1 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  bg_rom_arbiter #(.ADDR_W(17), .DATA_W(4), .ROM_LAT(3), .STARVE_MAX(8)) dut3 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  // ROM models
  always @(posedge vga_clk) bus1.rom_q <= bus1.rom_addr[3:0];
  logic [3:0] rom3_a, rom3_b;
  always @(posedge vga_clk) begin
    rom3_a     <= bus3.rom_addr[3:0];
    rom3_b     <= rom3_a;
    bus3.rom_q <= rom3_b;
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    bus1.disp_req = 1'b1; bus1.disp_addr = 17'h5;
    bus1.cpu_req  = 1'b1; bus1.cpu_addr  = 17'hA;
    bus3.disp_req = 1'b0; bus3.disp_addr = '0;
    bus3.cpu_req  = 1'b0; bus3.cpu_addr  = '0;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (bus1.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %0h expected 0", bus1.rom_en); end
    checks++; if (bus1.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt: got %0h expected 0", bus1.cpu_gnt); end
    checks++; if ({bus1.disp_valid, bus1.cpu_valid, bus1.disp_miss} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b expected 000", {bus1.disp_valid, bus1.cpu_valid, bus1.disp_miss}); end
    checks++; if ({bus1.disp_data, bus1.cpu_data} !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", {bus1.disp_data, bus1.cpu_data}); end
    bus1.disp_req = 1'b0; bus1.cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_disp_single();
    bus1.disp_req = 1'b1; bus1.disp_addr = 17'h00005;
    #1;
    checks++; if (bus1.rom_en !== 1'b1 || bus1.rom_addr !== 17'h5) begin errors++; $display("FAIL disp_issue: got en=%0h addr=%0h expected en=1 addr=5", bus1.rom_en, bus1.rom_addr); end
    tick();
    bus1.disp_req = 1'b0;
    checks++; if (bus1.disp_valid !== 1'b0) begin errors++; $display("FAIL disp_early_valid: got %0h expected 0", bus1.disp_valid); end
    tick();
    checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_data !== 4'h5) begin errors++; $display("FAIL disp_result: got v=%0h d=%0h expected v=1 d=5", bus1.disp_valid, bus1.disp_data); end
    tick();
    checks++; if (bus1.disp_valid !== 1'b0 || bus1.disp_data !== 4'h5) begin errors++; $display("FAIL disp_hold: got v=%0h d=%0h expected v=0 d=5", bus1.disp_valid, bus1.disp_data); end
  endtask

  task automatic test_cpu_pending();
    bus1.cpu_req = 1'b1; bus1.cpu_addr = 17'h0000A;
    for (int i = 0; i < 4; i++) begin
      bus1.disp_req = 1'b1; bus1.disp_addr = 17'(i + 1);
      #1;
      checks++; if (bus1.cpu_gnt !== 1'b0 || bus1.rom_addr !== 17'(i + 1)) begin errors++; $display("FAIL pend_disp_wins[%0d]: got gnt=%0h addr=%0h expected gnt=0 addr=%0h", i, bus1.cpu_gnt, bus1.rom_addr, i + 1); end
      tick();
    end
    bus1.disp_req = 1'b0;
    #1;
    checks++; if (bus1.cpu_gnt !== 1'b1 || bus1.rom_en !== 1'b1 || bus1.rom_addr !== 17'hA) begin errors++; $display("FAIL pend_gnt: got gnt=%0h en=%0h addr=%0h expected 1 1 a", bus1.cpu_gnt, bus1.rom_en, bus1.rom_addr); end
    tick();
    bus1.cpu_req = 1'b0;
    checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_data !== 4'h4 || bus1.cpu_valid !== 1'b0) begin errors++; $display("FAIL pend_last_disp: got v=%0h d=%0h cv=%0h expected 1 4 0", bus1.disp_valid, bus1.disp_data, bus1.cpu_valid); end
    tick();
    checks++; if (bus1.cpu_valid !== 1'b1 || bus1.cpu_data !== 4'hA || bus1.disp_valid !== 1'b0 || bus1.disp_data !== 4'h4) begin errors++; $display("FAIL pend_cpu_result: got cv=%0h cd=%0h dv=%0h dd=%0h expected 1 a 0 4", bus1.cpu_valid, bus1.cpu_data, bus1.disp_valid, bus1.disp_data); end
    tick();
  endtask

`ifdef BG_ARB_STARVE_EN
  task automatic test_starve();
    for (int c = 0; c < 12; c++) begin
      if (c >= 2 && c <= 9) begin
        checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_miss !== 1'b0 || bus1.disp_data !== 4'h3) begin errors++; $display("FAIL starve_disp[%0d]: got v=%0h m=%0h d=%0h expected 1 0 3", c, bus1.disp_valid, bus1.disp_miss, bus1.disp_data); end
      end
      if (c == 10) begin
        checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_miss !== 1'b1 || bus1.disp_data !== 4'h3) begin errors++; $display("FAIL starve_miss: got v=%0h m=%0h d=%0h expected 1 1 3", bus1.disp_valid, bus1.disp_miss, bus1.disp_data); end
        checks++; if (bus1.cpu_valid !== 1'b1 || bus1.cpu_data !== 4'hC) begin errors++; $display("FAIL starve_cpu_data: got v=%0h d=%0h expected 1 c", bus1.cpu_valid, bus1.cpu_data); end
      end
      if (c == 11) begin
        checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_miss !== 1'b0 || bus1.disp_data !== 4'h7) begin errors++; $display("FAIL starve_after: got v=%0h m=%0h d=%0h expected 1 0 7", bus1.disp_valid, bus1.disp_miss, bus1.disp_data); end
      end
      bus1.disp_req  = 1'b1;
      bus1.disp_addr = (c < 8) ? 17'h3 : 17'h7;
      bus1.cpu_req   = (c <= 9);
      bus1.cpu_addr  = (c <= 8) ? 17'hC : 17'hB;
      #1;
      if (c <= 9) begin
        checks++; if (bus1.cpu_gnt !== (c == 8)) begin errors++; $display("FAIL starve_gnt[%0d]: got %0h expected %0h", c, bus1.cpu_gnt, (c == 8)); end
      end
      if (c == 8) begin
        checks++; if (bus1.rom_addr !== 17'hC) begin errors++; $display("FAIL starve_addr: got %0h expected c", bus1.rom_addr); end
      end
      tick();
    end
    bus1.disp_req = 1'b0; bus1.cpu_req = 1'b0;
    tick(); tick(); tick();
  endtask
`else
  task automatic test_no_starve();
    for (int c = 0; c < 12; c++) begin
      if (c >= 2) begin
        checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_miss !== 1'b0 || bus1.disp_data !== ((c - 2 < 8) ? 4'h3 : 4'h7) || bus1.cpu_valid !== 1'b0) begin errors++; $display("FAIL nostarve_disp[%0d]: got v=%0h m=%0h d=%0h cv=%0h", c, bus1.disp_valid, bus1.disp_miss, bus1.disp_data, bus1.cpu_valid); end
      end
      bus1.disp_req  = 1'b1;
      bus1.disp_addr = (c < 8) ? 17'h3 : 17'h7;
      bus1.cpu_req   = 1'b1;
      bus1.cpu_addr  = 17'hC;
      #1;
      checks++; if (bus1.cpu_gnt !== 1'b0) begin errors++; $display("FAIL nostarve_gnt[%0d]: got %0h expected 0", c, bus1.cpu_gnt); end
      tick();
    end
    bus1.disp_req = 1'b0;
    #1;
    checks++; if (bus1.cpu_gnt !== 1'b1) begin errors++; $display("FAIL nostarve_release_gnt: got %0h expected 1", bus1.cpu_gnt); end
    tick();
    bus1.cpu_req = 1'b0;
    tick();
    checks++; if (bus1.cpu_valid !== 1'b1 || bus1.cpu_data !== 4'hC || bus1.disp_miss !== 1'b0) begin errors++; $display("FAIL nostarve_cpu: got v=%0h d=%0h m=%0h expected 1 c 0", bus1.cpu_valid, bus1.cpu_data, bus1.disp_miss); end
    tick();
  endtask
`endif

  task automatic test_reset_inflight();
    bus1.disp_req = 1'b1; bus1.disp_addr = 17'h9;
    tick();
    bus1.disp_req = 1'b0; bus1.cpu_req = 1'b1; bus1.cpu_addr = 17'h6;
    tick();
    reset_n = 1'b0; bus1.cpu_req = 1'b0;
    #1;
    checks++; if ({bus1.disp_valid, bus1.cpu_valid} !== 2'b00 || {bus1.disp_data, bus1.cpu_data} !== 8'h00 || bus1.rom_en !== 1'b0) begin errors++; $display("FAIL inflight_in_reset: got dv=%0h cv=%0h dd=%0h cd=%0h en=%0h expected all 0", bus1.disp_valid, bus1.cpu_valid, bus1.disp_data, bus1.cpu_data, bus1.rom_en); end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus1.disp_valid, bus1.cpu_valid} !== 2'b00 || {bus1.disp_data, bus1.cpu_data} !== 8'h00) begin errors++; $display("FAIL inflight_after[%0d]: got dv=%0h cv=%0h dd=%0h cd=%0h expected all 0", i, bus1.disp_valid, bus1.cpu_valid, bus1.disp_data, bus1.cpu_data); end
    end
    bus1.disp_req = 1'b1; bus1.disp_addr = 17'hE;
    tick();
    bus1.disp_req = 1'b0;
    tick();
    checks++; if (bus1.disp_valid !== 1'b1 || bus1.disp_data !== 4'hE) begin errors++; $display("FAIL inflight_next: got v=%0h d=%0h expected 1 e", bus1.disp_valid, bus1.disp_data); end
    tick();
  endtask

  task automatic test_lat3_alternate();
    for (int c = 0; c < 11; c++) begin
      int i;
      i = c - 4;
      if (i >= 0 && i < 6) begin
        if (i % 2 == 0) begin
          checks++; if (bus3.disp_valid !== 1'b1 || bus3.disp_data !== 4'(i + 1) || bus3.cpu_valid !== 1'b0) begin errors++; $display("FAIL lat3_disp[%0d]: got dv=%0h dd=%0h cv=%0h expected 1 %0h 0", c, bus3.disp_valid, bus3.disp_data, bus3.cpu_valid, i + 1); end
        end else begin
          checks++; if (bus3.cpu_valid !== 1'b1 || bus3.cpu_data !== 4'(i + 1) || bus3.disp_valid !== 1'b0) begin errors++; $display("FAIL lat3_cpu[%0d]: got cv=%0h cd=%0h dv=%0h expected 1 %0h 0", c, bus3.cpu_valid, bus3.cpu_data, bus3.disp_valid, i + 1); end
        end
      end else begin
        checks++; if ({bus3.disp_valid, bus3.cpu_valid} !== 2'b00) begin errors++; $display("FAIL lat3_idle[%0d]: got %b expected 00", c, {bus3.disp_valid, bus3.cpu_valid}); end
      end
      if (c < 6) begin
        bus3.disp_req  = (c % 2 == 0);
        bus3.cpu_req   = (c % 2 == 1);
        bus3.disp_addr = 17'(c + 1);
        bus3.cpu_addr  = 17'(c + 1);
        #1;
        checks++; if (bus3.cpu_gnt !== (c % 2 == 1) || bus3.rom_en !== 1'b1) begin errors++; $display("FAIL lat3_gnt[%0d]: got gnt=%0h en=%0h expected gnt=%0h en=1", c, bus3.cpu_gnt, bus3.rom_en, (c % 2 == 1)); end
      end else begin
        bus3.disp_req = 1'b0;
        bus3.cpu_req  = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_disp_single();
    test_cpu_pending();
`ifdef BG_ARB_STARVE_EN
    test_starve();
`else
    test_no_starve();
`endif
    test_reset_inflight();
    test_lat3_alternate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bg_rom_arbiter.md
BG_ROM_ARBITER -- requirements
Module: bg_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, ROM address width (320x240 background).
REQ-002 SHALL have parameter DATA_W, default 4, palette-index width.
REQ-003 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles; legal range 1..4.
REQ-004 SHALL have parameter STARVE_MAX, default 8, consecutive CPU-denied cycles before a forced CPU slot.
REQ-005 SHALL use one clock and an asynchronous active-low reset, ports listed first:
vga_clk  in  1  pixel clock; all state on posedge.
reset_n  in  1  asynchronous active-low reset.
disp_req  in  1  display pixel fetch request this cycle.
disp_addr  in  ADDR_W  display fetch address.
disp_valid  out  1  display data valid pulse.
disp_data  out  DATA_W  display palette index.
disp_miss  out  1  display read replaced by CPU slot; disp_data repeats the last value.
cpu_req  in  1  game-logic read request; held until granted.
cpu_addr  in  ADDR_W  CPU read address; stable while cpu_req is high.
cpu_gnt  out  1  combinational grant; request consumed this cycle.
cpu_valid  out  1  CPU data valid pulse.
cpu_data  out  DATA_W  CPU read result.
rom_en  out  1  ROM read issue strobe.
rom_addr  out  ADDR_W  ROM address, combinational mux of winner.
rom_q  in  DATA_W  ROM data, ROM_LAT cycles after issue.

Function
REQ-006 SHALL pick one owner per cycle: DISP if disp_req and not forced; else CPU if cpu_req; else none; rom_en=1 iff owner is not none.
REQ-007 SHALL assert cpu_gnt only in the cycle CPU owns the port; rom_addr=cpu_addr then, else disp_addr.
REQ-008 SHALL carry a {valid, owner} tag through a ROM_LAT-stage shift register aligned with rom_q.
REQ-009 SHALL register rom_q into disp_data or cpu_data per tag owner; valid pulses one cycle; total latency issue-to-valid = ROM_LAT+1.
REQ-010 SHALL hold disp_data and cpu_data at their last value when not updated.
REQ-011 SHALL issue back-to-back reads every cycle with no bubbles; throughput one read per cycle.
REQ-012 SHALL keep the starvation counter, saturating at STARVE_MAX: it increments each cycle cpu_req=1 and cpu_gnt=0, and clears on cpu_gnt or cpu_req=0.
REQ-013 SHALL treat a CPU request that arrives during a display burst as pending until the display idles (hblank/vblank); no timeout error.

Reset
REQ-014 SHALL, on reset_n low, asynchronously clear all tags, the counter, disp_valid, cpu_valid, disp_miss, disp_data and cpu_data to 0; cpu_gnt and rom_en evaluate to 0 while in reset.
REQ-015 SHALL discard reads in flight at reset; no valid pulse for them after release.

Configuration
REQ-016 SHALL use macro BG_ARB_STARVE_EN. If defined: when the counter equals STARVE_MAX, CPU wins even with disp_req=1, and the displaced display read returns disp_miss=1 with disp_valid=1 and the prior disp_data, at normal latency. If undefined: display always wins, the counter is absent and disp_miss is tied 0.

Structure
REQ-017 SHALL place ADDR_W/DATA_W defaults, owner enum (OWN_NONE, OWN_DISP, OWN_CPU) and the tag struct in package bg_arb_pkg.
REQ-018 SHALL implement the tag delay line as sub-module bg_arb_tag_pipe, parameterised by ROM_LAT.

Verification (ROM_LAT=1, STARVE_MAX=8, ROM model returns addr[3:0])
REQ-019 Display only, disp_addr=0x00005 at cycle 10 -> rom_en=1 at cycle 10; disp_valid=1, disp_data=0x5 at cycle 12.
REQ-020 cpu_req with cpu_addr=0x0000A during disp_req=1 burst ending cycle 20 -> cpu_gnt at cycle 21; cpu_valid=1, cpu_data=0xA at cycle 23.
REQ-021 disp_req and cpu_req both high at idle -> display wins; cpu_gnt stays 0 until disp_req falls.
REQ-022 BG_ARB_STARVE_EN defined, continuous disp_req, cpu_req from cycle 0 -> cpu_gnt at cycle 8; at cycle 10 disp_valid=1, disp_miss=1, disp_data unchanged; counter cleared.
REQ-023 reset_n low for one cycle with two reads in flight -> no valid pulses follow; outputs read 0; next request completes at normal latency.
REQ-024 ROM_LAT=3, alternating disp/cpu issues every cycle -> every valid appears exactly 4 cycles after its issue, routed to the correct owner.
